// File: rtl/stream_arb2.sv
// Two-channel valid/ready stream arbiter with a registered output slot and round-robin priority.
// Optional packet lock (grant held until last beat) is enabled by defining ARB2_LOCK_EN.
module stream_arb2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in_0,
    input  logic             valid_in_0,
    output logic             ready_out_0,
    input  logic [WIDTH-1:0] data_in_1,
    input  logic             valid_in_1,
    output logic             ready_out_1,
`ifdef ARB2_LOCK_EN
    input  logic             last_in_0,
    input  logic             last_in_1,
    output logic             last_out,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             sel
);

    logic             prio;
    logic             slot_free;
    logic             grant_valid;
    logic             grant_ch;
    logic             accept;
    logic             acc_ch;
    logic [WIDTH-1:0] acc_data;
    logic             acc_final;

`ifdef ARB2_LOCK_EN
    typedef enum logic [1:0] {
        LOCK_NONE,
        LOCK_CH0,
        LOCK_CH1
    } lock_t;

    lock_t lock_state;
    lock_t lock_next;
    logic  acc_last;

    assign acc_last  = acc_ch ? last_in_1 : last_in_0;
    assign acc_final = acc_last;
`else
    assign acc_final = 1'b1;
`endif

    assign slot_free = ~valid_out | ready_in;

    // An open packet pins the grant to its channel even if the other one is waiting.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = 1'b0;
        if (valid_in_0 && valid_in_1) begin
            grant_valid = 1'b1;
            grant_ch    = prio;
        end else if (valid_in_0) begin
            grant_valid = 1'b1;
            grant_ch    = 1'b0;
        end else if (valid_in_1) begin
            grant_valid = 1'b1;
            grant_ch    = 1'b1;
        end
`ifdef ARB2_LOCK_EN
        if (lock_state == LOCK_CH0) begin
            grant_valid = valid_in_0;
            grant_ch    = 1'b0;
        end else if (lock_state == LOCK_CH1) begin
            grant_valid = valid_in_1;
            grant_ch    = 1'b1;
        end
`endif
    end

    // Masked by rst so nothing is reported accepted while the slot is being cleared.
    assign ready_out_0 = ~rst & slot_free & grant_valid & ~grant_ch;
    assign ready_out_1 = ~rst & slot_free & grant_valid &  grant_ch;

    assign accept   = ready_out_0 | ready_out_1;
    assign acc_ch   = ready_out_1;
    assign acc_data = acc_ch ? data_in_1 : data_in_0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            sel       <= 1'b0;
            valid_out <= 1'b0;
        end else if (accept) begin
            data_out  <= acc_data;
            sel       <= acc_ch;
            valid_out <= 1'b1;
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (accept && acc_final) begin
            prio <= ~acc_ch;
        end
    end

`ifdef ARB2_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_out <= 1'b0;
        end else if (accept) begin
            last_out <= acc_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_state <= LOCK_NONE;
        end else begin
            lock_state <= lock_next;
        end
    end

    always_comb begin
        lock_next = lock_state;
        if (accept) begin
            if (acc_last) begin
                lock_next = LOCK_NONE;
            end else begin
                lock_next = acc_ch ? LOCK_CH1 : LOCK_CH0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_arb2.sv
// Testbench for stream_arb2: directed scenarios plus randomized traffic against a beat-level model.
// Lock scenarios are compiled in when ARB2_LOCK_EN is defined.
module tb_stream_arb2;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_in_0, data_in_1;
    logic             valid_in_0, valid_in_1;
    logic             ready_out_0, ready_out_1;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             ready_in;
    logic             sel;
`ifdef ARB2_LOCK_EN
    logic             last_in_0, last_in_1, last_out;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: what the output slot holds and whose turn it is
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    bit               m_sel;
    int               m_turn;
    int               m_lock;
    bit               m_last;

    always #5 clk = ~clk;

    stream_arb2 #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in_0   (data_in_0),
        .valid_in_0  (valid_in_0),
        .ready_out_0 (ready_out_0),
        .data_in_1   (data_in_1),
        .valid_in_1  (valid_in_1),
        .ready_out_1 (ready_out_1),
`ifdef ARB2_LOCK_EN
        .last_in_0   (last_in_0),
        .last_in_1   (last_in_1),
        .last_out    (last_out),
`endif
        .data_out    (data_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .sel         (sel)
    );

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_data  = '0;
        m_sel   = 0;
        m_turn  = 0;
        m_lock  = -1;
        m_last  = 0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
        data_in_0  = '0;
        data_in_1  = '0;
        ready_in   = 1'b0;
`ifdef ARB2_LOCK_EN
        last_in_0  = 1'b1;
        last_in_1  = 1'b1;
`endif
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        valid_in_0 = 1'b1;
        data_in_0  = 8'hA5;
        valid_in_1 = 1'b0;
        ready_in   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (ready_out_0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready0 got %b want 0", ready_out_0); end
            checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", valid_out); end
            checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h want 00", data_out); end
            checks++; if (sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel got %b want 0", sel); end
`ifdef ARB2_LOCK_EN
            checks++; if (last_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got %b want 0", last_out); end
`endif
            tick();
        end
    endtask

    task automatic test_single();
        do_reset();
        valid_in_1 = 1'b1;
        data_in_1  = 8'h3C;
        ready_in   = 1'b1;
        #2;
        checks++; if (ready_out_1 !== 1'b1) begin errors++; $display("[TB] FAIL single_ready1 got %b want 1", ready_out_1); end
        checks++; if (ready_out_0 !== 1'b0) begin errors++; $display("[TB] FAIL single_ready0 got %b want 0", ready_out_0); end
        tick();
        valid_in_1 = 1'b0;
        data_in_1  = 8'hEE;
        checks++; if (data_out !== 8'h3C) begin errors++; $display("[TB] FAIL single_data got %h want 3c", data_out); end
        checks++; if (sel !== 1'b1) begin errors++; $display("[TB] FAIL single_sel got %b want 1", sel); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b want 1", valid_out); end
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid got %b want 0", valid_out); end
        checks++; if (data_out !== 8'h3C) begin errors++; $display("[TB] FAIL drain_data_hold got %h want 3c", data_out); end
        checks++; if (sel !== 1'b1) begin errors++; $display("[TB] FAIL drain_sel_hold got %b want 1", sel); end
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] want;
        do_reset();
        valid_in_0 = 1'b1;
        valid_in_1 = 1'b1;
        data_in_0  = 8'h10;
        data_in_1  = 8'h20;
        ready_in   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            checks++; if ((ready_out_0 & ready_out_1) !== 1'b0) begin errors++; $display("[TB] FAIL rr_exclusive got %b%b want not 11", ready_out_0, ready_out_1); end
            tick();
            want = (k % 2 == 0) ? 8'h10 : 8'h20;
            checks++; if (data_out !== want) begin errors++; $display("[TB] FAIL rr_data[%0d] got %h want %h", k, data_out, want); end
            checks++; if (sel !== 1'(k % 2)) begin errors++; $display("[TB] FAIL rr_sel[%0d] got %b want %0d", k, sel, k % 2); end
            checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL rr_valid[%0d] got %b want 1", k, valid_out); end
        end
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        valid_in_0 = 1'b1;
        data_in_0  = 8'h55;
        ready_in   = 1'b1;
        tick();
        valid_in_0 = 1'b0;
        ready_in   = 1'b0;
        valid_in_1 = 1'b1;
        data_in_1  = 8'h66;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if ({ready_out_0, ready_out_1} !== 2'b00) begin errors++; $display("[TB] FAIL bp_ready[%0d] got %b%b want 00", c, ready_out_0, ready_out_1); end
            tick();
            checks++; if (data_out !== 8'h55) begin errors++; $display("[TB] FAIL bp_hold[%0d] got %h want 55", c, data_out); end
            checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d] got %b want 1", c, valid_out); end
        end
        ready_in = 1'b1;
        #2;
        checks++; if (ready_out_1 !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %b want 1", ready_out_1); end
        tick();
        valid_in_1 = 1'b0;
        checks++; if (data_out !== 8'h66) begin errors++; $display("[TB] FAIL bp_release_data got %h want 66", data_out); end
        checks++; if (sel !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_sel got %b want 1", sel); end
    endtask

    task automatic test_mid_stall_reset();
        do_reset();
        valid_in_1 = 1'b1;
        data_in_1  = 8'h77;
        ready_in   = 1'b1;
        tick();
        valid_in_1 = 1'b0;
        ready_in   = 1'b0;
        tick();
        checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL msr_stall_valid got %b want 1", valid_out); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL msr_async_valid got %b want 0", valid_out); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL msr_async_data got %h want 00", data_out); end
        valid_in_0 = 1'b1;
        valid_in_1 = 1'b1;
        ready_in   = 1'b1;
        #1;
        checks++; if ({ready_out_0, ready_out_1} !== 2'b00) begin errors++; $display("[TB] FAIL msr_ready_in_reset got %b%b want 00", ready_out_0, ready_out_1); end
        tick();
        rst       = 1'b0;
        data_in_0 = 8'hAA;
        data_in_1 = 8'hBB;
        #2;
        checks++; if ({ready_out_0, ready_out_1} !== 2'b10) begin errors++; $display("[TB] FAIL msr_first_grant got %b%b want 10", ready_out_0, ready_out_1); end
        tick();
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
        checks++; if (data_out !== 8'hAA) begin errors++; $display("[TB] FAIL msr_first_data got %h want aa", data_out); end
        checks++; if (sel !== 1'b0) begin errors++; $display("[TB] FAIL msr_first_sel got %b want 0", sel); end
    endtask

`ifdef ARB2_LOCK_EN
    task automatic test_lock();
        logic [WIDTH-1:0] beat;
        do_reset();
        ready_in   = 1'b1;
        valid_in_1 = 1'b1;
        data_in_1  = 8'hB1;
        last_in_1  = 1'b1;
        valid_in_0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            beat      = 8'hC0 + 8'(k);
            data_in_0 = beat;
            last_in_0 = (k == 2);
            tick();
            checks++; if (sel !== 1'b0) begin errors++; $display("[TB] FAIL lock_sel[%0d] got %b want 0", k, sel); end
            checks++; if (data_out !== beat) begin errors++; $display("[TB] FAIL lock_data[%0d] got %h want %h", k, data_out, beat); end
            checks++; if (last_out !== (k == 2)) begin errors++; $display("[TB] FAIL lock_last[%0d] got %b want %0d", k, last_out, k == 2); end
        end
        data_in_0 = 8'hC3;
        last_in_0 = 1'b1;
        tick();
        checks++; if (sel !== 1'b1) begin errors++; $display("[TB] FAIL lock_release_sel got %b want 1", sel); end
        checks++; if (data_out !== 8'hB1) begin errors++; $display("[TB] FAIL lock_release_data got %h want b1", data_out); end
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
    endtask
`endif

    // Random traffic: each cycle the model decides which pending beat (if any) wins the slot
    task automatic test_random();
        int         winner;
        bit         v[2];
        bit         l[2];
        logic [7:0] d[2];
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v[0] = ($urandom_range(0, 9) < 6);
            v[1] = ($urandom_range(0, 9) < 6);
            d[0] = 8'($urandom);
            d[1] = 8'($urandom);
            l[0] = ($urandom_range(0, 9) < 4);
            l[1] = ($urandom_range(0, 9) < 4);
            valid_in_0 = v[0];
            valid_in_1 = v[1];
            data_in_0  = d[0];
            data_in_1  = d[1];
            ready_in   = ($urandom_range(0, 9) < 7);
`ifdef ARB2_LOCK_EN
            last_in_0  = l[0];
            last_in_1  = l[1];
`endif
            winner = -1;
            if (!m_valid || ready_in) begin
                if (m_lock >= 0)
                    winner = v[m_lock] ? m_lock : -1;
                else if (v[0] && v[1])
                    winner = m_turn;
                else if (v[0])
                    winner = 0;
                else if (v[1])
                    winner = 1;
            end
            #2;
            checks++; if (ready_out_0 !== (winner == 0)) begin errors++; $display("[TB] FAIL rand_ready0[%0d] got %b want %0d", n, ready_out_0, winner == 0); end
            checks++; if (ready_out_1 !== (winner == 1)) begin errors++; $display("[TB] FAIL rand_ready1[%0d] got %b want %0d", n, ready_out_1, winner == 1); end
            if (winner >= 0) begin
                m_valid = 1;
                m_data  = d[winner];
                m_sel   = 1'(winner);
`ifdef ARB2_LOCK_EN
                m_last  = l[winner];
                if (l[winner]) begin
                    m_lock = -1;
                    m_turn = 1 - winner;
                end else begin
                    m_lock = winner;
                end
`else
                m_turn  = 1 - winner;
`endif
            end else if (ready_in) begin
                m_valid = 0;
            end
            tick();
            checks++; if (valid_out !== m_valid) begin errors++; $display("[TB] FAIL rand_valid[%0d] got %b want %b", n, valid_out, m_valid); end
            checks++; if (data_out !== m_data) begin errors++; $display("[TB] FAIL rand_data[%0d] got %h want %h", n, data_out, m_data); end
            checks++; if (sel !== m_sel) begin errors++; $display("[TB] FAIL rand_sel[%0d] got %b want %b", n, sel, m_sel); end
`ifdef ARB2_LOCK_EN
            checks++; if (last_out !== m_last) begin errors++; $display("[TB] FAIL rand_last[%0d] got %b want %b", n, last_out, m_last); end
`endif
        end
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
        data_in_0  = '0;
        data_in_1  = '0;
        ready_in   = 1'b0;
`ifdef ARB2_LOCK_EN
        last_in_0  = 1'b1;
        last_in_1  = 1'b1;
`endif
        model_reset();
        tick();
        $display("[TB] starting stream_arb2 tests");
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mid_stall_reset();
`ifdef ARB2_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
